// File: rtl/alu_result_writeback.sv
// rtl/alu_result_writeback.sv - ALU result writeback, load/store handshake and next-PC generation
module alu_result_writeback #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] alu_result,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] program_counter,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            pc_load,
    output logic [XLEN-1:0] pc_next,
    output logic            instr_done,
    output logic            fault
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_J     = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUI   = 7'b0010111;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MEM  = 2'd1;
    localparam logic [1:0] WB   = 2'd2;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]      state;
    logic [TW-1:0]   tcnt;
    logic [6:0]      op_q;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] alu_q, pc_q;

    // Decode works on live inputs while accepting and on the captured copy afterwards.
    logic [6:0]      sel_op;
    logic [2:0]      sel_f3;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_alu, sel_pc;
    assign sel_op  = (state == IDLE) ? opcode          : op_q;
    assign sel_f3  = (state == IDLE) ? funct3          : f3_q;
    assign sel_rd  = (state == IDLE) ? rd              : rd_q;
    assign sel_alu = (state == IDLE) ? alu_result      : alu_q;
    assign sel_pc  = (state == IDLE) ? program_counter : pc_q;

    logic            is_load, is_store, f3_legal, misaligned, access_ok, writes_rd, wb_fault;
    logic [3:0]      be_calc;
    logic [XLEN-1:0] wdata_calc, lane, ld_data, pc_plus4, wb_pc, wb_data;

    assign is_load    = (sel_op == OP_LOAD);
    assign is_store   = (sel_op == OP_STORE);
    assign misaligned = ((sel_f3[1:0] == 2'b01) && sel_alu[0]) ||
                        ((sel_f3[1:0] == 2'b10) && (sel_alu[1:0] != 2'b00));
    assign access_ok  = f3_legal && !misaligned;
    assign lane       = mem_rdata >> {sel_alu[1:0], 3'b000};
    assign pc_plus4   = sel_pc + XLEN'(4);
    // Leaving MEM without an ack can only mean the request timed out.
    assign wb_fault   = (state == MEM) ? !mem_ack : ((is_load || is_store) && !access_ok);

    always_comb begin
        f3_legal   = 1'b0;
        be_calc    = 4'b1111;
        wdata_calc = rs2;
        ld_data    = lane;
        writes_rd  = 1'b0;
        case (sel_f3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = is_load;
            default:                f3_legal = 1'b0;
        endcase
        case (sel_f3[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << sel_alu[1:0];
                wdata_calc = {(XLEN/8){rs2[7:0]}};
            end
            2'b01: begin
                be_calc    = 4'b0011 << {sel_alu[1], 1'b0};
                wdata_calc = {(XLEN/16){rs2[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = rs2;
            end
        endcase
        case (sel_f3)
            3'b000:  ld_data = {{(XLEN-8){lane[7]}}, lane[7:0]};
            3'b001:  ld_data = {{(XLEN-16){lane[15]}}, lane[15:0]};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, lane[7:0]};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, lane[15:0]};
            default: ld_data = lane;
        endcase
        case (sel_op)
            OP_R, OP_I, OP_LOAD, OP_J, OP_JALR, OP_LUI, OP_AUI: writes_rd = 1'b1;
            default: writes_rd = 1'b0;
        endcase
    end

    always_comb begin
        wb_pc   = pc_plus4;
        wb_data = sel_alu;
        if (!wb_fault) begin
            case (sel_op)
                OP_J:    wb_pc = sel_alu;
                OP_JALR: wb_pc = {sel_alu[XLEN-1:1], 1'b0};
                OP_B:    wb_pc = branch_taken ? sel_alu : pc_plus4;
                default: wb_pc = pc_plus4;
            endcase
        end
        case (sel_op)
            OP_J, OP_JALR: wb_data = pc_plus4;
            OP_LOAD:       wb_data = ld_data;
            default:       wb_data = sel_alu;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tcnt       <= '0;
            op_q       <= '0;
            f3_q       <= '0;
            rd_q       <= '0;
            alu_q      <= '0;
            pc_q       <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            pc_load    <= 1'b0;
            pc_next    <= '0;
            instr_done <= 1'b0;
            fault      <= 1'b0;
        end else begin
            rf_we      <= 1'b0;
            pc_load    <= 1'b0;
            instr_done <= 1'b0;
            fault      <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        op_q  <= opcode;
                        f3_q  <= funct3;
                        rd_q  <= rd;
                        alu_q <= alu_result;
                        pc_q  <= program_counter;
                        if ((is_load || is_store) && access_ok) begin
                            state     <= MEM;
                            tcnt      <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {alu_result[XLEN-1:2], 2'b00};
                            mem_wdata <= wdata_calc;
                            mem_be    <= be_calc;
                        end else begin
                            state      <= WB;
                            rf_we      <= writes_rd && (rd != 5'd0) && !wb_fault;
                            rf_waddr   <= rd;
                            rf_wdata   <= wb_data;
                            pc_load    <= 1'b1;
                            pc_next    <= wb_pc;
                            instr_done <= 1'b1;
                            fault      <= wb_fault;
                        end
                    end
                end
                MEM: begin
                    if (mem_ack || (tcnt == T_LAST)) begin
                        state      <= WB;
                        mem_req    <= 1'b0;
                        rf_we      <= writes_rd && (sel_rd != 5'd0) && !wb_fault;
                        rf_waddr   <= sel_rd;
                        rf_wdata   <= wb_data;
                        pc_load    <= 1'b1;
                        pc_next    <= wb_pc;
                        instr_done <= 1'b1;
                        fault      <= wb_fault;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_writeback.sv
// tb/tb_alu_result_writeback.sv - randomized and directed bench for alu_result_writeback
module tb_alu_result_writeback;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_B = 7'b1100011, OP_J = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUI = 7'b0010111,
                           OP_FENCE = 7'b0001111;

    logic        clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0, branch_taken = 1'b0, mem_ack = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rd = '0;
    logic [31:0] alu_result = '0, rs2 = '0, program_counter = '0, mem_rdata = '0;
    logic        mem_req, mem_we, rf_we, pc_load, instr_done, fault;
    logic [31:0] mem_addr, mem_wdata, rf_wdata, pc_next;
    logic [3:0]  mem_be;
    logic [4:0]  rf_waddr;

    always #5 clk = ~clk;

    alu_result_writeback #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode), .funct3(funct3),
        .rd(rd), .alu_result(alu_result), .branch_taken(branch_taken), .rs2(rs2),
        .program_counter(program_counter), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pc_load(pc_load), .pc_next(pc_next), .instr_done(instr_done), .fault(fault)
    );

    int n_checks = 0, n_pass = 0;

    // Observations gathered while one instruction runs.
    int          ob_cycles, ob_req;
    logic        ob_done, ob_stable, ob_idle_clean, ob_we, ob_rf_we, ob_pc_load, ob_fault;
    logic [31:0] ob_addr, ob_wdata, ob_rf_wdata, ob_pc_next;
    logic [3:0]  ob_be;
    logic [4:0]  ob_rf_waddr;

    // Memory responds with ack in request cycle ack_at; stray drives ack while no request is open.
    task automatic exec(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                        input logic [31:0] alu, input logic br, input logic [31:0] d2,
                        input logic [31:0] pc, input int ack_at, input logic [31:0] rdata,
                        input logic stray);
        opcode = op; funct3 = f3; rd = r; alu_result = alu; branch_taken = br; rs2 = d2;
        program_counter = pc; instr_valid = 1'b1; mem_ack = stray;
        ob_cycles = 0; ob_req = 0; ob_done = 1'b0; ob_stable = 1'b1;
        ob_we = 1'b0; ob_addr = '0; ob_be = '0; ob_wdata = '0;
        ob_rf_we = 1'b0; ob_rf_waddr = '0; ob_rf_wdata = '0; ob_pc_load = 1'b0;
        ob_pc_next = '0; ob_fault = 1'b0;
        for (int c = 0; c < 40 && !ob_done; c++) begin
            @(negedge clk);
            ob_cycles++;
            if (instr_done) begin
                ob_done = 1'b1; ob_rf_we = rf_we; ob_rf_waddr = rf_waddr; ob_rf_wdata = rf_wdata;
                ob_pc_load = pc_load; ob_pc_next = pc_next; ob_fault = fault;
            end
            if (mem_req) begin
                if (ob_req == 0) begin
                    ob_we = mem_we; ob_addr = mem_addr; ob_be = mem_be; ob_wdata = mem_wdata;
                end else if (ob_we !== mem_we || ob_addr !== mem_addr || ob_be !== mem_be ||
                             ob_wdata !== mem_wdata) begin
                    ob_stable = 1'b0;
                end
                ob_req++;
            end
            mem_ack   = mem_req ? (ob_req == ack_at) : stray;
            mem_rdata = (mem_req && ob_req == ack_at) ? rdata : $urandom;
        end
        instr_valid = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        ob_idle_clean = !(instr_done || rf_we || pc_load || fault || mem_req);
    endtask

    // Reference model: expected behaviour derived directly from the access and writeback rules.
    task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                         input logic [31:0] alu, input logic br, input logic [31:0] d2,
                         input logic [31:0] pc, input int ack_at, input logic [31:0] rdata,
                         output logic e_we, output logic [31:0] e_addr, output logic [3:0] e_be,
                         output logic [31:0] e_wdata, output logic e_rfwe,
                         output logic [31:0] e_rfdata, output logic [31:0] e_pc,
                         output logic e_fault, output int e_lat, output int e_req);
        bit is_ld, is_st, legal, go, to;
        int nbytes, off;
        logic [31:0] mask, v;
        is_ld  = (op == OP_LD);
        is_st  = (op == OP_ST);
        nbytes = 1 << f3[1:0];
        legal  = is_ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        go     = (is_ld || is_st) && legal && (alu % nbytes == 0);
        to     = go && ack_at > 16;
        e_fault = ((is_ld || is_st) && !go) || to;
        off    = alu % 4;
        mask   = (nbytes >= 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nbytes)) - 32'd1;
        e_we   = is_st;
        e_addr = alu - off;
        e_be   = 4'(((32'd1 << nbytes) - 32'd1) << off);
        e_wdata = (nbytes == 1) ? (d2 & 32'hFF) * 32'h0101_0101 :
                  (nbytes == 2) ? (d2 & 32'hFFFF) * 32'h0001_0001 : d2;
        v = (rdata >> (8 * off)) & mask;
        if (!f3[2] && nbytes < 4 && ((v >> (8 * nbytes - 1)) & 32'd1) == 32'd1) v = v | ~mask;
        e_rfwe   = (op inside {OP_R, OP_I, OP_LD, OP_J, OP_JALR, OP_LUI, OP_AUI}) && r != 0 && !e_fault;
        e_rfdata = (op == OP_J || op == OP_JALR) ? pc + 32'd4 : is_ld ? v : alu;
        e_pc     = e_fault ? pc + 32'd4 : (op == OP_J) ? alu : (op == OP_JALR) ? (alu & ~32'd1) :
                   (op == OP_B && br) ? alu : pc + 32'd4;
        e_lat    = go ? (to ? 17 : ack_at + 1) : 1;
        e_req    = go ? (to ? 16 : ack_at) : 0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++; if ({mem_req, rf_we, pc_load, instr_done, fault} !== 5'b0) $display("FAIL reset_ctl got %b want 00000", {mem_req, rf_we, pc_load, instr_done, fault}); else n_pass++;
        n_checks++; if ({pc_next, rf_wdata, mem_addr} !== 96'h0) $display("FAIL reset_data got %h/%h/%h want 0", pc_next, rf_wdata, mem_addr); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if ({mem_req, instr_done} !== 2'b0) $display("FAIL reset_idle got %b want 00", {mem_req, instr_done}); else n_pass++;
    endtask

    task automatic test_rtype;
        exec(OP_R, 3'd0, 5'd5, 32'h12, 1'b0, 32'h0, 32'h100, 1, 32'h0, 1'b1);
        n_checks++; if (!ob_done || ob_cycles != 1) $display("FAIL rtype_latency got %0d (done %b) want 1", ob_cycles, ob_done); else n_pass++;
        n_checks++; if ({ob_rf_we, ob_rf_waddr, ob_rf_wdata} !== {1'b1, 5'd5, 32'h12}) $display("FAIL rtype_rf got %b/%0d/%h want 1/5/12", ob_rf_we, ob_rf_waddr, ob_rf_wdata); else n_pass++;
        n_checks++; if ({ob_pc_load, ob_pc_next, ob_fault} !== {1'b1, 32'h104, 1'b0}) $display("FAIL rtype_pc got %b/%h/%b want 1/104/0", ob_pc_load, ob_pc_next, ob_fault); else n_pass++;
        n_checks++; if (ob_req != 0 || !ob_idle_clean) $display("FAIL rtype_quiet got req %0d clean %b want 0 1", ob_req, ob_idle_clean); else n_pass++;
    endtask

    task automatic test_loads;
        exec(OP_LD, 3'b000, 5'd7, 32'h203, 1'b0, 32'h0, 32'h200, 3, 32'h80FF_FF00, 1'b0);
        n_checks++; if ({ob_we, ob_addr, ob_be} !== {1'b0, 32'h200, 4'b1000}) $display("FAIL lb_req got %b/%h/%b want 0/200/1000", ob_we, ob_addr, ob_be); else n_pass++;
        n_checks++; if (ob_req != 3 || ob_cycles != 4 || !ob_stable) $display("FAIL lb_timing got req %0d lat %0d stable %b want 3 4 1", ob_req, ob_cycles, ob_stable); else n_pass++;
        n_checks++; if ({ob_rf_we, ob_rf_wdata} !== {1'b1, 32'hFFFF_FF80}) $display("FAIL lb_data got %b/%h want 1/ffffff80", ob_rf_we, ob_rf_wdata); else n_pass++;
        exec(OP_LD, 3'b100, 5'd7, 32'h203, 1'b0, 32'h0, 32'h200, 3, 32'h80FF_FF00, 1'b0);
        n_checks++; if ({ob_rf_we, ob_rf_wdata} !== {1'b1, 32'h0000_0080}) $display("FAIL lbu_data got %b/%h want 1/00000080", ob_rf_we, ob_rf_wdata); else n_pass++;
    endtask

    task automatic test_store;
        exec(OP_ST, 3'b001, 5'd3, 32'h102, 1'b0, 32'h0000_ABCD, 32'h80, 2, 32'h0, 1'b0);
        n_checks++; if ({ob_we, ob_be, ob_wdata} !== {1'b1, 4'b1100, 32'hABCD_ABCD}) $display("FAIL sh_req got %b/%b/%h want 1/1100/abcdabcd", ob_we, ob_be, ob_wdata); else n_pass++;
        n_checks++; if ({ob_rf_we, ob_pc_next, ob_fault} !== {1'b0, 32'h84, 1'b0}) $display("FAIL sh_wb got %b/%h/%b want 0/84/0", ob_rf_we, ob_pc_next, ob_fault); else n_pass++;
    endtask

    task automatic test_jalr;
        exec(OP_JALR, 3'd0, 5'd1, 32'h401, 1'b0, 32'h0, 32'h40, 1, 32'h0, 1'b0);
        n_checks++; if ({ob_rf_we, ob_rf_wdata, ob_pc_next} !== {1'b1, 32'h44, 32'h400}) $display("FAIL jalr got %b/%h/%h want 1/44/400", ob_rf_we, ob_rf_wdata, ob_pc_next); else n_pass++;
        exec(OP_JALR, 3'd0, 5'd0, 32'h401, 1'b0, 32'h0, 32'h40, 1, 32'h0, 1'b0);
        n_checks++; if ({ob_rf_we, ob_pc_next} !== {1'b0, 32'h400}) $display("FAIL jalr_x0 got %b/%h want 0/400", ob_rf_we, ob_pc_next); else n_pass++;
    endtask

    task automatic test_faults;
        exec(OP_LD, 3'b010, 5'd9, 32'h101, 1'b0, 32'h0, 32'h300, 1, 32'h0, 1'b0);
        n_checks++; if (ob_req != 0 || ob_cycles != 1 || {ob_fault, ob_rf_we, ob_pc_next} !== {1'b1, 1'b0, 32'h304}) $display("FAIL lw_misalign got req %0d lat %0d %b/%b/%h want 0 1 1/0/304", ob_req, ob_cycles, ob_fault, ob_rf_we, ob_pc_next); else n_pass++;
        exec(OP_LD, 3'b011, 5'd9, 32'h100, 1'b0, 32'h0, 32'h300, 1, 32'h0, 1'b0);
        n_checks++; if (ob_req != 0 || ob_cycles != 1 || {ob_fault, ob_rf_we, ob_pc_next} !== {1'b1, 1'b0, 32'h304}) $display("FAIL ld_f3_011 got req %0d lat %0d %b/%b/%h want 0 1 1/0/304", ob_req, ob_cycles, ob_fault, ob_rf_we, ob_pc_next); else n_pass++;
        n_checks++; if (!ob_idle_clean) $display("FAIL fault_pulse got lingering outputs want one-cycle pulse"); else n_pass++;
    endtask

    task automatic test_timeout_reset;
        int done_seen;
        exec(OP_ST, 3'b010, 5'd0, 32'h500, 1'b0, 32'h1234_5678, 32'h600, 99, 32'h0, 1'b0);
        n_checks++; if (ob_req != 16 || ob_cycles != 17 || !ob_done) $display("FAIL sw_timeout got req %0d lat %0d done %b want 16 17 1", ob_req, ob_cycles, ob_done); else n_pass++;
        n_checks++; if ({ob_fault, ob_rf_we, ob_pc_next} !== {1'b1, 1'b0, 32'h604}) $display("FAIL sw_timeout_wb got %b/%b/%h want 1/0/604", ob_fault, ob_rf_we, ob_pc_next); else n_pass++;
        opcode = OP_ST; funct3 = 3'b010; alu_result = 32'h500; instr_valid = 1'b1; mem_ack = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (mem_req !== 1'b1) $display("FAIL mid_mem_req got %b want 1", mem_req); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL async_reset_req got %b want 0", mem_req); else n_pass++;
        instr_valid = 1'b0;
        done_seen = 0;
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (instr_done || mem_req) done_seen++;
        end
        n_checks++; if (done_seen != 0) $display("FAIL reset_abort got %0d activity cycles want 0", done_seen); else n_pass++;
    endtask

    task automatic test_random;
        logic [6:0]  ops [10] = '{OP_R, OP_I, OP_LD, OP_ST, OP_B, OP_J, OP_JALR, OP_LUI, OP_AUI, OP_FENCE};
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  r;
        logic [31:0] alu, d2, pc, rdata, e_addr, e_wdata, e_rfdata, e_pc;
        logic        br, e_we, e_rfwe, e_fault;
        logic [3:0]  e_be;
        int          ack_at, e_lat, e_req;
        for (int i = 0; i < 150; i++) begin
            op = ops[$urandom_range(0, 9)];
            f3 = 3'($urandom);
            r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            alu = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 63));
            br = 1'($urandom);
            d2 = $urandom; pc = $urandom & ~32'd3; rdata = $urandom;
            ack_at = ($urandom_range(0, 11) == 0) ? 20 : $urandom_range(1, 5);
            model(op, f3, r, alu, br, d2, pc, ack_at, rdata, e_we, e_addr, e_be, e_wdata,
                  e_rfwe, e_rfdata, e_pc, e_fault, e_lat, e_req);
            exec(op, f3, r, alu, br, d2, pc, ack_at, rdata, ($urandom_range(0, 3) == 0) && !(op inside {OP_LD, OP_ST}));
            n_checks++; if (!ob_done || ob_cycles != e_lat || ob_req != e_req) $display("FAIL rand%0d_timing got lat %0d req %0d done %b want %0d %0d", i, ob_cycles, ob_req, ob_done, e_lat, e_req); else n_pass++;
            n_checks++; if ({ob_fault, ob_rf_we, ob_pc_load, ob_pc_next} !== {e_fault, e_rfwe, 1'b1, e_pc}) $display("FAIL rand%0d_wb got %b/%b/%b/%h want %b/%b/1/%h", i, ob_fault, ob_rf_we, ob_pc_load, ob_pc_next, e_fault, e_rfwe, e_pc); else n_pass++;
            if (e_rfwe) begin
                n_checks++; if ({ob_rf_waddr, ob_rf_wdata} !== {r, e_rfdata}) $display("FAIL rand%0d_rf got %0d/%h want %0d/%h", i, ob_rf_waddr, ob_rf_wdata, r, e_rfdata); else n_pass++;
            end
            if (e_req > 0) begin
                n_checks++; if ({ob_we, ob_addr, ob_be} !== {e_we, e_addr, e_be} || !ob_stable) $display("FAIL rand%0d_req got %b/%h/%b stable %b want %b/%h/%b", i, ob_we, ob_addr, ob_be, ob_stable, e_we, e_addr, e_be); else n_pass++;
                if (e_we) begin
                    n_checks++; if (ob_wdata !== e_wdata) $display("FAIL rand%0d_wdata got %h want %h", i, ob_wdata, e_wdata); else n_pass++;
                end
            end
            n_checks++; if (!ob_idle_clean) $display("FAIL rand%0d_pulse got lingering outputs want idle", i); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_loads();
        test_store();
        test_jalr();
        test_faults();
        test_timeout_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_result_writeback.md
Name: alu_result_writeback

Overview:
Consumer side of the ALU operand path. Takes the ALU result for the current RV32I instruction and either writes it back or uses it as a data-memory address. Loads and stores run a request/acknowledge handshake to data memory. The block then produces the register-file write, the next PC and a completion pulse. It sits between the ALU output and the register file, PC register and data-memory port.

Parameters:
XLEN, 32, datapath width (RV32I_OPERAND_t)
TIMEOUT_CYCLES, 16, maximum mem_req cycles without mem_ack before the access is aborted

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
instr_valid  input  1  instruction and ALU result valid; sampled only in IDLE
opcode  input  7  RV32I_OPCODE_t of the instruction
funct3  input  3  load/store width and signedness
rd  input  5  destination register index
alu_result  input  32  ALU output: address for load/store, target for J/B/JALR, value otherwise
branch_taken  input  1  branch condition result for B_TYPE
rs2  input  32  store data
program_counter  input  32  PC of the instruction
mem_req  output  1  data-memory request
mem_we  output  1  1 = store, 0 = load
mem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
mem_wdata  output  32  lane-replicated store data
mem_be  output  4  byte enables
mem_ack  input  1  access complete; mem_rdata valid for loads
mem_rdata  input  32  load data word
rf_we  output  1  register-file write enable
rf_waddr  output  5  write index
rf_wdata  output  32  write data
pc_load  output  1  load pc_next into the PC
pc_next  output  32  next PC
instr_done  output  1  one-cycle completion pulse
fault  output  1  one-cycle pulse with instr_done: misaligned access, illegal funct3, or timeout

Behaviour:
- Reset (asynchronous, immediate): state = IDLE, timeout counter = 0, all outputs = 0. Reset during MEM drops mem_req at once. The aborted instruction is never completed.
- States: IDLE, MEM, WB.
- IDLE:
  - On instr_valid, register all inputs.
  - If opcode is I_LOAD_TYPE or S_TYPE and the access is legal, go to MEM. Otherwise go to WB.
  - instr_valid in MEM or WB is ignored. Upstream holds it until instr_done.
- Access legality:
  - Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: funct3 000 SB, 001 SH, 010 SW.
  - Any other funct3 is illegal.
  - Halfword access with addr[0]=1 is misaligned; word access with addr[1:0]≠0 is misaligned.
  - Illegal or misaligned: no mem_req, go to WB with fault set.
- mem_be for loads and stores: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
- mem_wdata: byte replicated ×4, half replicated ×2, word as is.
- MEM:
  - mem_req=1 with mem_we/addr/wdata/be stable until the cycle mem_ack=1.
  - On mem_ack: for loads, extract the lane at the byte offset, sign- or zero-extend per funct3, register it; go to WB.
  - If mem_ack has not arrived after TIMEOUT_CYCLES request cycles: drop mem_req, set fault, go to WB with no register write.
  - mem_ack outside MEM is ignored.
- WB (exactly one cycle, registered outputs):
  - instr_done=1, pc_load=1, then return to IDLE.
  - rf_we=1 for R_TYPE, I_TYPE, I_LOAD_TYPE, J_TYPE, I_JALR_TYPE, U_LUI_TYPE, U_AUI_TYPE, only when rd≠0 and no fault.
  - rf_wdata: J/JALR → pc+4; load → extracted data; otherwise alu_result.
  - pc_next: J_TYPE → alu_result; JALR → alu_result & ~32'h1; B_TYPE with branch_taken → alu_result; all other cases, including faults → pc+4 (mod 2^32).
  - Outside WB: rf_we, pc_load, instr_done and fault are 0.
- Latency:
  - Non-memory: accept in cycle N, WB in N+1. Minimum two cycles per instruction.
  - Memory: mem_req high from N+1; mem_ack in cycle M; WB in M+1.

Test Plan:
- R_TYPE, rd=5, alu_result=0x12, pc=0x100 → next cycle: rf_we=1, waddr=5, wdata=0x12, pc_next=0x104, instr_done=1, fault=0.
- LB, alu_result=0x203; mem_ack after 3 request cycles with mem_rdata=0x80FF_FF00 → mem_addr=0x200, mem_be=4'b1000, mem_we=0; WB wdata=0xFFFF_FF80. Repeat as LBU → wdata=0x0000_0080.
- SH, alu_result=0x102, rs2=0x0000_ABCD → mem_we=1, mem_be=4'b1100, mem_wdata=0xABCD_ABCD; WB has rf_we=0, pc_next=pc+4.
- I_JALR_TYPE, alu_result=0x401, pc=0x40, rd=1 → pc_next=0x400, rf_wdata=0x44. Same instruction with rd=0 → rf_we=0.
- LW at 0x101, and separately load with funct3=011 → mem_req never asserted; WB one cycle after accept with fault=1, rf_we=0, pc_next=pc+4.
- SW with mem_ack held 0 → mem_req high exactly 16 cycles, then fault=1 and instr_done=1. A second SW with rst_n asserted mid-MEM → mem_req=0 immediately, no instr_done.
